// File: rtl/instr_encoder_if.sv
// Command and instruction-memory write channels of the program loader.
// The host drives the command side; the encoder drives the output side.
interface instr_encoder_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_kind;
   logic [4:0]  cmd_rd;
   logic [4:0]  cmd_rs;
   logic [4:0]  cmd_rt;
   logic [25:0] cmd_imm;
   logic        cmd_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_word;
   logic [31:0] out_addr;

   modport master (
      output cmd_valid,
      output cmd_kind,
      output cmd_rd,
      output cmd_rs,
      output cmd_rt,
      output cmd_imm,
      output cmd_last,
      input  cmd_ready,
      input  out_valid,
      input  out_word,
      input  out_addr,
      output out_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_kind,
      input  cmd_rd,
      input  cmd_rs,
      input  cmd_rt,
      input  cmd_imm,
      input  cmd_last,
      output cmd_ready,
      output out_valid,
      output out_word,
      output out_addr,
      input  out_ready
   );
endinterface

// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic commands into MIPS words, queues them and emits them with
// word addresses. Define INSTR_ENC_CHECKSUM_EN to add an XOR checksum of emitted words.
module instr_encoder #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         start_i,
   instr_encoder_if.slave bus_io,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_illegal_o,
   output logic [7:0]   err_count_o
`ifdef INSTR_ENC_CHECKSUM_EN
   ,
   output logic [31:0]  checksum_o
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

   localparam logic [3:0] KindAddu  = 4'd0;
   localparam logic [3:0] KindSubu  = 4'd1;
   localparam logic [3:0] KindAnd   = 4'd2;
   localparam logic [3:0] KindOr    = 4'd3;
   localparam logic [3:0] KindSltu  = 4'd4;
   localparam logic [3:0] KindLw    = 4'd5;
   localparam logic [3:0] KindSw    = 4'd6;
   localparam logic [3:0] KindBeq   = 4'd7;
   localparam logic [3:0] KindAddiu = 4'd8;
   localparam logic [3:0] KindJ     = 4'd9;
   localparam logic [3:0] KindLui   = 4'd10;
   localparam logic [3:0] KindOri   = 4'd11;
   localparam logic [3:0] KindBltz  = 4'd12;

   typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [31:0]     mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [31:0]     addr_q, addr_d;
   logic            err_illegal_q, err_illegal_d;
   logic [7:0]      err_count_q, err_count_d;

   logic            full, empty;
   logic            start_ok, accept, push, pop;
   logic            legal;
   logic [31:0]     enc_word;

   // ---------------------------------------------------------------- encoder
   always_comb begin
      legal    = 1'b1;
      enc_word = '0;
      case (bus_io.cmd_kind)
         KindAddu:  enc_word = {6'h00, bus_io.cmd_rs, bus_io.cmd_rt, bus_io.cmd_rd, 5'b0, 6'h21};
         KindSubu:  enc_word = {6'h00, bus_io.cmd_rs, bus_io.cmd_rt, bus_io.cmd_rd, 5'b0, 6'h23};
         KindAnd:   enc_word = {6'h00, bus_io.cmd_rs, bus_io.cmd_rt, bus_io.cmd_rd, 5'b0, 6'h24};
         KindOr:    enc_word = {6'h00, bus_io.cmd_rs, bus_io.cmd_rt, bus_io.cmd_rd, 5'b0, 6'h25};
         KindSltu:  enc_word = {6'h00, bus_io.cmd_rs, bus_io.cmd_rt, bus_io.cmd_rd, 5'b0, 6'h2B};
         KindLw:    enc_word = {6'h23, bus_io.cmd_rs, bus_io.cmd_rt, bus_io.cmd_imm[15:0]};
         KindSw:    enc_word = {6'h2B, bus_io.cmd_rs, bus_io.cmd_rt, bus_io.cmd_imm[15:0]};
         KindBeq:   enc_word = {6'h04, bus_io.cmd_rs, bus_io.cmd_rt, bus_io.cmd_imm[15:0]};
         KindAddiu: enc_word = {6'h09, bus_io.cmd_rs, bus_io.cmd_rt, bus_io.cmd_imm[15:0]};
         KindJ:     enc_word = {6'h02, bus_io.cmd_imm};
         KindLui:   enc_word = {6'h0F, 5'b0, bus_io.cmd_rt, bus_io.cmd_imm[15:0]};
         KindOri:   enc_word = {6'h0D, bus_io.cmd_rs, bus_io.cmd_rt, bus_io.cmd_imm[15:0]};
         KindBltz:  enc_word = {6'h01, bus_io.cmd_rs, 5'b0, bus_io.cmd_imm[15:0]};
         default:   legal    = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------- handshakes
   assign full             = (count_q == FullCount);
   assign empty            = (count_q == '0);
   // No write-through: a full FIFO refuses even when a pop happens this cycle.
   assign bus_io.cmd_ready = (state_q == StLoad) && !full;
   assign bus_io.out_valid = !empty;
   assign bus_io.out_word  = empty ? 32'h0 : mem_q[rd_ptr_q];
   assign bus_io.out_addr  = addr_q;

   assign start_ok = start_i && ((state_q == StIdle) || (state_q == StDone));
   assign accept   = bus_io.cmd_valid && bus_io.cmd_ready;
   assign push     = accept && legal;
   assign pop      = bus_io.out_valid && bus_io.out_ready;

   // ---------------------------------------------------------------- FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_ok) state_d = StLoad;
         StLoad:  if (accept && bus_io.cmd_last) state_d = StDrain;
         StDrain: if (empty) state_d = StDone;
         StDone:  if (start_ok) state_d = StLoad;
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------- datapath next state
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      addr_d        = addr_q;
      err_illegal_d = accept && !legal;
      err_count_d   = err_count_q;

      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      if (push && !pop) begin
         count_d = count_q + (AW+1)'(1);
      end else if (!push && pop) begin
         count_d = count_q - (AW+1)'(1);
      end

      if (start_ok) begin
         addr_d = BASE_ADDR;
      end else if (pop) begin
         addr_d = addr_q + 32'd4;
      end

      if (start_ok) begin
         err_count_d = '0;
      end else if (accept && !legal && (err_count_q != 8'hFF)) begin
         err_count_d = err_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= StIdle;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         addr_q        <= BASE_ADDR;
         err_illegal_q <= 1'b0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         addr_q        <= addr_d;
         err_illegal_q <= err_illegal_d;
         err_count_q   <= err_count_d;
      end
   end

   // Storage needs no reset: out_word is masked to zero while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= enc_word;
      end
   end

   assign busy_o        = (state_q == StLoad) || (state_q == StDrain);
   assign done_o        = (state_q == StDone);
   assign err_illegal_o = err_illegal_q;
   assign err_count_o   = err_count_q;

`ifdef INSTR_ENC_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (start_ok) begin
         checksum_d = '0;
      end else if (pop) begin
         checksum_d = checksum_q ^ bus_io.out_word;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum_o = checksum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, addressing, backpressure, illegal kinds and reset.
module tb_instr_encoder;

   logic        clk;
   logic        reset;
   logic        start;
   logic        busy;
   logic        done;
   logic        err_illegal;
   logic [7:0]  err_count;
`ifdef INSTR_ENC_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   instr_encoder_if bus ();

   instr_encoder #(
      .DEPTH     (4),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .start_i       (start),
      .bus_io        (bus),
      .busy_o        (busy),
      .done_o        (done),
      .err_illegal_o (err_illegal),
      .err_count_o   (err_count)
`ifdef INSTR_ENC_CHECKSUM_EN
      ,
      .checksum_o    (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, failures=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drive_cmd(input logic [3:0] kind, input logic [4:0] rd, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [25:0] imm, input logic last);
      bus.cmd_valid = 1'b1;
      bus.cmd_kind  = kind;
      bus.cmd_rd    = rd;
      bus.cmd_rs    = rs;
      bus.cmd_rt    = rt;
      bus.cmd_imm   = imm;
      bus.cmd_last  = last;
   endtask

   task automatic idle_cmd();
      bus.cmd_valid = 1'b0;
      bus.cmd_last  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
      end
      n_checks++;
      if (bus.out_word !== 32'h0) begin
         n_fail++; $display("FAIL reset_out_word: got %h want 00000000", bus.out_word);
      end
      n_checks++;
      if (bus.out_addr !== 32'h0) begin
         n_fail++; $display("FAIL reset_out_addr: got %h want 00000000", bus.out_addr);
      end
      n_checks++;
      if ({bus.cmd_ready, busy, done, err_illegal} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: ready/busy/done/err got %b want 0000",
                  {bus.cmd_ready, busy, done, err_illegal});
      end
      n_checks++;
      if (err_count !== 8'd0) begin
         n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count);
      end
`ifdef INSTR_ENC_CHECKSUM_EN
      n_checks++;
      if (checksum !== 32'h0) begin
         n_fail++; $display("FAIL reset_checksum: got %h want 00000000", checksum);
      end
`endif
   endtask

   task automatic test_addu();
      bus.out_ready = 1'b0;
      do_start();
      n_checks++;
      if ({busy, bus.cmd_ready} !== 2'b11) begin
         n_fail++; $display("FAIL start_load: busy/ready got %b want 11", {busy, bus.cmd_ready});
      end
      drive_cmd(4'd0, 5'd3, 5'd1, 5'd2, 26'd0, 1'b1);
      tick();
      idle_cmd();
      n_checks++;
      if ({bus.out_valid, bus.out_word, bus.out_addr} !== {1'b1, 32'h00221821, 32'h0}) begin
         n_fail++;
         $display("FAIL addu_word: valid=%b word=%h addr=%h want 1 00221821 00000000",
                  bus.out_valid, bus.out_word, bus.out_addr);
      end
      n_checks++;
      if ({busy, bus.cmd_ready} !== 2'b10) begin
         n_fail++; $display("FAIL addu_drain: busy/ready got %b want 10", {busy, bus.cmd_ready});
      end
      bus.out_ready = 1'b1;
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_addr} !== {1'b0, 32'h4}) begin
         n_fail++;
         $display("FAIL addu_pop: valid=%b addr=%h want 0 00000004", bus.out_valid, bus.out_addr);
      end
      tick();
      n_checks++;
      if ({done, busy} !== 2'b10) begin
         n_fail++; $display("FAIL addu_done: done/busy got %b want 10", {done, busy});
      end
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      do_start();
      n_checks++;
      if (bus.out_addr !== 32'h0) begin
         n_fail++; $display("FAIL b2b_start_addr: got %h want 00000000", bus.out_addr);
      end
      drive_cmd(4'd5, 5'd0, 5'd29, 5'd8, 26'd4, 1'b0);
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_word, bus.out_addr} !== {1'b1, 32'h8FA80004, 32'h0}) begin
         n_fail++;
         $display("FAIL lw_word: valid=%b word=%h addr=%h want 1 8fa80004 00000000",
                  bus.out_valid, bus.out_word, bus.out_addr);
      end
      drive_cmd(4'd9, 5'd0, 5'd0, 5'd0, 26'h100, 1'b1);
      tick();
      idle_cmd();
      n_checks++;
      if ({bus.out_valid, bus.out_word, bus.out_addr} !== {1'b1, 32'h08000100, 32'h4}) begin
         n_fail++;
         $display("FAIL j_word: valid=%b word=%h addr=%h want 1 08000100 00000004",
                  bus.out_valid, bus.out_word, bus.out_addr);
      end
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_addr} !== {1'b0, 32'h8}) begin
         n_fail++;
         $display("FAIL b2b_empty: valid=%b addr=%h want 0 00000008", bus.out_valid, bus.out_addr);
      end
`ifdef INSTR_ENC_CHECKSUM_EN
      n_checks++;
      if (checksum !== 32'h87A80104) begin
         n_fail++; $display("FAIL checksum_xor: got %h want 87a80104", checksum);
      end
`endif
      tick();
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL b2b_done: got %b want 1", done);
      end
   endtask

   task automatic test_forced_fields();
      bus.out_ready = 1'b0;
      do_start();
      drive_cmd(4'd10, 5'd0, 5'd7, 5'd1, 26'h1234, 1'b0);
      tick();
      drive_cmd(4'd12, 5'd0, 5'd5, 5'd9, 26'hFFFE, 1'b1);
      tick();
      idle_cmd();
      n_checks++;
      if ({bus.out_word, bus.out_addr} !== {32'h3C011234, 32'h0}) begin
         n_fail++;
         $display("FAIL lui_word: word=%h addr=%h want 3c011234 00000000",
                  bus.out_word, bus.out_addr);
      end
      bus.out_ready = 1'b1;
      tick();
      n_checks++;
      if ({bus.out_valid, bus.out_word, bus.out_addr} !== {1'b1, 32'h04A0FFFE, 32'h4}) begin
         n_fail++;
         $display("FAIL bltz_word: valid=%b word=%h addr=%h want 1 04a0fffe 00000004",
                  bus.out_valid, bus.out_word, bus.out_addr);
      end
      tick();
      tick();
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL forced_done: got %b want 1", done);
      end
   endtask

   task automatic test_full();
      logic [31:0] exp_words [5];
      exp_words[0] = 32'h344300FF;  // ORI rs=2 rt=3 imm=00ff
      exp_words[1] = 32'h00A62023;  // SUBU rd=4 rs=5 rt=6
      exp_words[2] = 32'h01093824;  // AND rd=7 rs=8 rt=9
      exp_words[3] = 32'h1022FFFD;  // BEQ rs=1 rt=2 imm=fffd
      exp_words[4] = 32'hAFBF0008;  // SW rs=29 rt=31 imm=8
      bus.out_ready = 1'b0;
      do_start();
      drive_cmd(4'd11, 5'd0, 5'd2, 5'd3, 26'h00FF, 1'b0);
      tick();
      drive_cmd(4'd1, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0);
      tick();
      drive_cmd(4'd2, 5'd7, 5'd8, 5'd9, 26'd0, 1'b0);
      tick();
      n_checks++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL full_ready_3: got %b want 1", bus.cmd_ready);
      end
      drive_cmd(4'd7, 5'd0, 5'd1, 5'd2, 26'hFFFD, 1'b0);
      tick();
      drive_cmd(4'd6, 5'd0, 5'd29, 5'd31, 26'd8, 1'b1);
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({bus.cmd_ready, bus.out_word, bus.out_addr} !== {1'b0, exp_words[0], 32'h0}) begin
            n_fail++;
            $display("FAIL full_hold_%0d: ready=%b word=%h addr=%h want 0 %h 00000000",
                     i, bus.cmd_ready, bus.out_word, bus.out_addr, exp_words[0]);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      // First pop frees a slot; the SW is only taken on the following edge.
      tick();
      n_checks++;
      if (bus.cmd_ready !== 1'b1) begin
         n_fail++; $display("FAIL full_ready_after_pop: got %b want 1", bus.cmd_ready);
      end
      for (int i = 1; i < 5; i++) begin
         n_checks++;
         if ({bus.out_valid, bus.out_word, bus.out_addr} !== {1'b1, exp_words[i], 32'(4 * i)}) begin
            n_fail++;
            $display("FAIL drain_word_%0d: valid=%b word=%h addr=%h want 1 %h %h", i,
                     bus.out_valid, bus.out_word, bus.out_addr, exp_words[i], 32'(4 * i));
         end
         tick();
         if (i == 1) idle_cmd();
      end
      n_checks++;
      if ({bus.out_valid, bus.out_addr} !== {1'b0, 32'd20}) begin
         n_fail++;
         $display("FAIL drain_empty: valid=%b addr=%h want 0 00000014",
                  bus.out_valid, bus.out_addr);
      end
      tick();
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++; $display("FAIL full_done: got %b want 1", done);
      end
   endtask

   task automatic test_illegal();
      bus.out_ready = 1'b1;
      do_start();
      drive_cmd(4'd14, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1);
      tick();
      idle_cmd();
      n_checks++;
      if ({bus.out_valid, err_illegal, busy} !== 3'b011) begin
         n_fail++;
         $display("FAIL illegal_pulse: valid/err/busy got %b want 011",
                  {bus.out_valid, err_illegal, busy});
      end
      n_checks++;
      if (err_count !== 8'd1) begin
         n_fail++; $display("FAIL illegal_count: got %0d want 1", err_count);
      end
      tick();
      n_checks++;
      if ({err_illegal, done} !== 2'b01) begin
         n_fail++; $display("FAIL illegal_done: err/done got %b want 01", {err_illegal, done});
      end
      do_start();
      n_checks++;
      if (err_count !== 8'd0) begin
         n_fail++; $display("FAIL start_clears_count: got %0d want 0", err_count);
      end
   endtask

   task automatic test_reset_mid();
      // Session already in LOAD from the previous task.
      bus.out_ready = 1'b0;
      drive_cmd(4'd8, 5'd0, 5'd1, 5'd2, 26'h10, 1'b0);
      tick();
      drive_cmd(4'd3, 5'd3, 5'd4, 5'd5, 26'd0, 1'b0);
      tick();
      drive_cmd(4'd4, 5'd6, 5'd7, 5'd8, 26'd0, 1'b0);
      tick();
      idle_cmd();
      n_checks++;
      if ({bus.out_valid, bus.out_word} !== {1'b1, 32'h24220010}) begin
         n_fail++;
         $display("FAIL addiu_queued: valid=%b word=%h want 1 24220010",
                  bus.out_valid, bus.out_word);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({bus.out_valid, busy, done, bus.cmd_ready} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid: valid/busy/done/ready got %b want 0000",
                  {bus.out_valid, busy, done, bus.cmd_ready});
      end
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_stays_empty: got %b want 0", bus.out_valid);
      end
   endtask

   initial begin
      reset         = 1'b1;
      start         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_kind  = 4'd0;
      bus.cmd_rd    = 5'd0;
      bus.cmd_rs    = 5'd0;
      bus.cmd_rt    = 5'd0;
      bus.cmd_imm   = 26'd0;
      bus.cmd_last  = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_addu();
      test_back_to_back();
      test_forced_fields();
      test_full();
      test_illegal();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
